store_monitor: RTL and testbench
================================

# store_monitor

Passive observer on the processor's data-memory write bus, downstream of `top` (consumes `MemWrite`, `DataAdr`, `WriteData`). It classifies every store as pass, scratch or illegal, runs a cycle-budget timeout, and latches a sticky verdict. It also logs each accepted store into a small FIFO that a bench or debug port drains through a valid/ready handshake.

## Interface
- `PASS_ADR`, 32'd100: store address that ends the run.
- `PASS_DATA`, 32'd10: value required at `PASS_ADR` for a pass.
- `SCRATCH_ADR`, 32'd96: the only other address the program may store to.
- `TIMEOUT`, 24: cycle budget after reset release.
- `CNT_W`, 8: width of the cycle and store counters.
- `DEPTH`, 8: log FIFO entries; must be a power of two, ≥2.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `MemWrite` in 1: store strobe from the core.
- `DataAdr` in 32: store address.
- `WriteData` in 32: store data.
- `done` out 1: verdict reached (any terminal state).
- `pass` out 1: terminal state PASS.
- `fail` out 1: terminal state FAIL.
- `timeout` out 1: terminal state TIMEOUT.
- `cycle_count` out CNT_W: cycles spent in RUN.
- `store_count` out CNT_W: stores observed in RUN, saturating.
- `log_valid` out 1: FIFO non-empty.
- `log_ready` in 1: consumer pops the head when `log_valid` is high.
- `log_adr` out 32: head entry address.
- `log_data` out 32: head entry data.
- `log_cycle` out CNT_W: `cycle_count` value when the head entry was captured.
- `overflow` out 1: sticky; a store was dropped because the FIFO was full.

## Operation
- States: RUN, PASS, FAIL, TIMEOUT. Reset enters RUN. PASS, FAIL and TIMEOUT are sticky until reset.
- A store is sampled at a rising edge while the state is RUN and `MemWrite`=1.
- Classification of a sampled store:
  - `DataAdr`==PASS_ADR and `WriteData`==PASS_DATA → PASS.
  - `DataAdr`==PASS_ADR with any other data → FAIL.
  - `DataAdr`==SCRATCH_ADR → stay in RUN.
  - Any other address → FAIL.
- Timeout: RUN with `cycle_count`==TIMEOUT and no store sampled at that edge → TIMEOUT.
- Precedence: a store verdict beats the timeout on the same edge.
- `cycle_count`: increments by 1 every edge in RUN and freezes in terminal states. It wraps modulo 2^CNT_W; TIMEOUT must be < 2^CNT_W.
- `store_count`: increments for every sampled store and saturates at all-ones.
- Logging: every sampled store, including the decisive one, is pushed as {adr, data, cycle_count before increment}.
  - Push while full and no pop → entry dropped, `overflow` set.
  - Push and pop on the same edge while full → both happen; no overflow.
- Pop: on `log_valid`&&`log_ready`. FIFO draining continues in every state.
- Stores are neither sampled nor logged in terminal states.
- Reset mid-run: all state, counters, FIFO pointers and `overflow` clear immediately, asynchronously.

## Timing
- Reset values: `done`=`pass`=`fail`=`timeout`=0, `cycle_count`=`store_count`=0, `log_valid`=0, `overflow`=0. `log_adr`/`log_data`/`log_cycle` are don't-care while `log_valid`=0.
- Verdict latency: the flags are registered outputs of the state. They are visible immediately after the edge that samples the deciding store, i.e. the core's following cycle; no combinational input-to-flag path.
- Log latency: an entry pushed at edge n gives `log_valid`=1 after edge n. FIFO head outputs are registered (FWFT).
- TIMEOUT=24 with reset released before edge 0: `timeout` rises after edge 24 unless a verdict came earlier.

## Structure
- Package `store_monitor_pkg`:
  - `mon_state_t` enum {RUN, PASS, FAIL, TIMEOUT}.
  - `store_entry_t` packed struct {adr[31:0], data[31:0], cycle[CNT_W-1:0]}, CNT_W-generic via a package parameter default of 8.
- Sub-module `store_log_fifo`: synchronous FWFT FIFO parameterised by DEPTH and entry type, with push, pop, full, empty and count. It owns overflow detection for a push while full without a pop.
- Top level holds the FSM, both counters and the classifier.

## Test plan
- Store (96, 7), then (100, 10) at cycle 5 → `pass`=`done`=1 after that edge; `store_count`=2; FIFO pops give (96,7,c) then (100,10,5).
- Store (100, 9) → `fail`=1. A later store (100, 10) changes nothing and is not logged.
- Store (64, 1) → `fail`=1 on that edge.
- No stores → `timeout`=1 after edge 24, `cycle_count` frozen at 25. Store (100, 10) on edge 24 → `pass`=1, not `timeout`.
- DEPTH=8, `log_ready`=0, nine (96, k) stores → `overflow`=1, eight entries k=0..7 retained. Repeat with `log_ready`=1 on the ninth edge → no overflow.
- Assert `reset` asynchronously mid-run after three logged stores → all outputs return to reset values before the next edge; monitoring restarts in RUN.

Source files
------------

// File: rtl/store_monitor_pkg.sv
// ============================================================================
// store_monitor_pkg : shared types for the data-memory store monitor
// Rev 1.0
// ============================================================================
`default_nettype none

package store_monitor_pkg;

    parameter int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } mon_state_t;

    typedef struct packed {
        logic [31:0]              adr;
        logic [31:0]              data;
        logic [CNT_W_DEFAULT-1:0] cycle;
    } store_entry_t;

endpackage

`default_nettype wire

// File: rtl/store_log_fifo.sv
// ============================================================================
// store_log_fifo : first-word-fall-through FIFO with sticky overflow flag
// Rev 1.0
// ============================================================================
`default_nettype none

module store_log_fifo
    import store_monitor_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = store_entry_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   wr_entry,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    entry_t          r_mem [DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            r_overflow;
    logic            w_do_push;
    logic            w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count     = r_wr_ptr - r_rd_ptr;
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign head      = r_mem[r_rd_ptr[AW-1:0]];
    assign overflow  = r_overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (push && !w_do_push) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_entry;
    end

endmodule

`default_nettype wire

// File: rtl/store_monitor.sv
// ============================================================================
// store_monitor : classifies core stores, tracks a cycle budget, logs stores
// Rev 1.0
// ============================================================================
`default_nettype none

module store_monitor
    import store_monitor_pkg::*;
#(
    parameter logic [31:0] PASS_ADR    = 32'd100,
    parameter logic [31:0] PASS_DATA   = 32'd10,
    parameter logic [31:0] SCRATCH_ADR = 32'd96,
    parameter int          TIMEOUT     = 24,
    parameter int          CNT_W       = 8,
    parameter int          DEPTH       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [31:0]       DataAdr,
    input  logic [31:0]       WriteData,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  store_count,
    output logic              log_valid,
    input  logic              log_ready,
    output logic [31:0]       log_adr,
    output logic [31:0]       log_data,
    output logic [CNT_W-1:0]  log_cycle,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

    typedef struct packed {
        logic [31:0]      adr;
        logic [31:0]      data;
        logic [CNT_W-1:0] cycle;
    } entry_t;

    mon_state_t           r_state;
    mon_state_t           w_next;
    logic [CNT_W-1:0]     r_cycle;
    logic [CNT_W-1:0]     r_stores;
    logic                 w_sample;
    entry_t               w_wr_entry;
    entry_t               w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic                 w_unused_fifo;

    assign w_sample = (r_state == ST_RUN) && MemWrite;

    // A sampled store always decides the edge; timeout only applies without one.
    always_comb begin
        w_next = r_state;
        if (r_state == ST_RUN) begin
            if (w_sample) begin
                if (DataAdr == PASS_ADR)
                    w_next = (WriteData == PASS_DATA) ? ST_PASS : ST_FAIL;
                else if (DataAdr != SCRATCH_ADR)
                    w_next = ST_FAIL;
            end else if (r_cycle == C_TIMEOUT) begin
                w_next = ST_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_cycle  <= '0;
            r_stores <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_RUN) r_cycle <= r_cycle + 1'b1;
            if (w_sample && (r_stores != '1)) r_stores <= r_stores + 1'b1;
        end
    end

    assign w_wr_entry = '{adr: DataAdr, data: WriteData, cycle: r_cycle};

    store_log_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_log (
        .clk      (clk),
        .reset    (reset),
        .push     (w_sample),
        .wr_entry (w_wr_entry),
        .pop      (log_ready),
        .head     (w_head),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count),
        .overflow (overflow)
    );

    assign w_unused_fifo = ^{w_full, w_count};

    assign done        = (r_state != ST_RUN);
    assign pass        = (r_state == ST_PASS);
    assign fail        = (r_state == ST_FAIL);
    assign timeout     = (r_state == ST_TIMEOUT);
    assign cycle_count = r_cycle;
    assign store_count = r_stores;
    assign log_valid   = !w_empty;
    assign log_adr     = w_head.adr;
    assign log_data    = w_head.data;
    assign log_cycle   = w_head.cycle;

endmodule

`default_nettype wire

// File: tb/tb_store_monitor.sv
// ============================================================================
// tb_store_monitor : directed + randomized checks against a queue-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_store_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        log_ready = 1'b0;
    logic        done, pass, fail, timeout, log_valid, overflow;
    logic [7:0]  cycle_count, store_count, log_cycle;
    logic [31:0] log_adr, log_data;

    store_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .store_count (store_count),
        .log_valid   (log_valid),
        .log_ready   (log_ready),
        .log_adr     (log_adr),
        .log_data    (log_data),
        .log_cycle   (log_cycle),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] c;
    } ent_t;

    int   errors = 0;
    int   checks = 0;
    // Model verdict: 0 running, 1 pass, 2 fail, 3 timeout
    int   m_state;
    int   m_cycle;
    int   m_stores;
    bit   m_ovf;
    ent_t m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_cycle  = 0;
        m_stores = 0;
        m_ovf    = 1'b0;
        m_q.delete();
    endtask

    task automatic model_edge(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rdy);
        bit   running, sample, was_full, popped;
        ent_t e;
        running  = (m_state == 0);
        sample   = running && we;
        was_full = (m_q.size() == 8);
        popped   = rdy && (m_q.size() > 0);
        if (popped) void'(m_q.pop_front());
        if (sample) begin
            if (!was_full || popped) begin
                e.a = a; e.d = d; e.c = m_cycle;
                m_q.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
            if (m_stores < 255) m_stores++;
            if (a == 32'd100)     m_state = (d == 32'd10) ? 1 : 2;
            else if (a != 32'd96) m_state = 2;
        end else if (running && m_cycle == 24) begin
            m_state = 3;
        end
        if (running) m_cycle = (m_cycle + 1) % 256;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/done"},    32'(done),        32'(m_state != 0));
        chk({tag, "/pass"},    32'(pass),        32'(m_state == 1));
        chk({tag, "/fail"},    32'(fail),        32'(m_state == 2));
        chk({tag, "/timeout"}, 32'(timeout),     32'(m_state == 3));
        chk({tag, "/cycles"},  32'(cycle_count), 32'(m_cycle));
        chk({tag, "/stores"},  32'(store_count), 32'(m_stores));
        chk({tag, "/valid"},   32'(log_valid),   32'(m_q.size() != 0));
        chk({tag, "/ovf"},     32'(overflow),    32'(m_ovf));
        if (m_q.size() != 0) begin
            chk({tag, "/log_adr"},   log_adr,        m_q[0].a);
            chk({tag, "/log_data"},  log_data,       m_q[0].d);
            chk({tag, "/log_cycle"}, 32'(log_cycle), m_q[0].c);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input bit rdy, input string tag);
        MemWrite  = we;
        DataAdr   = a;
        WriteData = d;
        log_ready = rdy;
        model_edge(we, a, d, rdy);
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
        MemWrite  = 1'b0;
        log_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_illegal();
        logic [31:0] a;
        a = $urandom;
        if (a == 32'd96 || a == 32'd100) a = a ^ 32'h0000_1000;
        return a;
    endfunction

    initial begin
        int          k;
        logic [31:0] d;

        @(negedge clk);

        // Pass at cycle 5 after one scratch store
        do_reset();
        k = $urandom_range(0, 4);
        d = $urandom;
        for (int e = 0; e < 5; e++) step(e == k, 32'd96, d, 1'b0, "pass_pre");
        step(1'b1, 32'd100, 32'd10, 1'b0, "pass_hit");
        chk("pass_flag", 32'(pass), 32'd1);
        chk("pass_count", 32'(store_count), 32'd2);
        chk("pass_head_adr", log_adr, 32'd96);
        chk("pass_head_data", log_data, d);
        chk("pass_head_cycle", 32'(log_cycle), 32'(k));
        step(1'b1, 32'd96, $urandom, 1'b1, "pass_pop1");
        chk("pass_head2", {log_adr[15:0], log_data[7:0], log_cycle}, {16'd100, 8'd10, 8'd5});
        for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1, "pass_drain");

        // Wrong data at the pass address, later correct store ignored
        do_reset();
        d = $urandom;
        if (d == 32'd10) d = 32'd11;
        for (int i = 0; i < 3; i++) step($urandom_range(0, 1) == 1, 32'd96, $urandom, 1'b0, "fail_pre");
        step(1'b1, 32'd100, d, 1'b0, "fail_hit");
        step(1'b1, 32'd100, 32'd10, 1'b0, "fail_after");
        chk("fail_sticky", 32'(fail), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1, "fail_drain");

        // Illegal address
        do_reset();
        step(1'b1, 32'd64, 32'd1, 1'b0, "illegal64");
        for (int i = 0; i < 3; i++) begin
            do_reset();
            step(1'b0, '0, '0, 1'b0, "ill_idle");
            step(1'b1, rand_illegal(), $urandom, 1'b0, "illegal_rand");
        end

        // Timeout with no stores
        do_reset();
        for (int i = 0; i < 30; i++) step(1'b0, '0, '0, 1'b0, "to_idle");
        chk("to_flag", 32'(timeout), 32'd1);
        chk("to_frozen", 32'(cycle_count), 32'd25);

        // Store verdict wins over timeout on edge 24
        do_reset();
        for (int i = 0; i < 24; i++) step(1'b0, '0, '0, 1'b0, "race_idle");
        step(1'b1, 32'd100, 32'd10, 1'b0, "race_hit");
        chk("race_pass", 32'(pass), 32'd1);
        chk("race_not_to", 32'(timeout), 32'd0);

        // Overflow: nine stores, no pops
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 32'd96, 32'(i), 1'b0, "ovf_fill");
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_head", log_data, 32'd0);
        for (int i = 0; i < 9; i++) step(1'b0, '0, '0, 1'b1, "ovf_drain");

        // Pop on the ninth push avoids overflow
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 32'd96, 32'(i), 1'b0, "noovf_fill");
        step(1'b1, 32'd96, 32'd8, 1'b1, "noovf_ninth");
        chk("noovf_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < 9; i++) step(1'b0, '0, '0, 1'b1, "noovf_drain");

        // Asynchronous reset mid-run
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 32'd96, $urandom, 1'b0, "ar_store");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("ar_async");
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 32'd96, 32'd5, 1'b0, "ar_restart");

        // Store counter saturation under continuous scratch stores
        do_reset();
        for (int i = 0; i < 260; i++) step(1'b1, 32'd96, $urandom, 1'b1, "sat");
        chk("sat_count", 32'(store_count), 32'd255);

        // Randomized mix of idle, scratch stores, pops and a final verdict
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 20; i++)
                step($urandom_range(0, 2) != 0, 32'd96, $urandom, $urandom_range(0, 3) == 0, "rnd");
            case ($urandom_range(0, 2))
                0:       step(1'b1, 32'd100, 32'd10, 1'b0, "rnd_end");
                1:       step(1'b1, 32'd100, $urandom_range(11, 1000), 1'b0, "rnd_end");
                default: step(1'b1, rand_illegal(), $urandom, 1'b0, "rnd_end");
            endcase
            for (int i = 0; i < 10; i++) step(1'b1, 32'd96, $urandom, 1'b1, "rnd_drain");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
